ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter: the send side of the keyboard link, complementing the existing PS/2 receiver.

---
 rtl/ps2_host_tx.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter (send side of the keyboard link).
//
// Sends one command byte to the device using the full host handshake:
//   1. clock inhibit
//   2. request-to-send (start bit)
//   3. eight data bits, odd parity, stop
//   4. device ACK
// Both PS/2 lines are driven open-drain: oe=1 pulls the line low, and oe=0
// releases it. The existing receiver keeps listening on the same pins.
//
// Ports
//   sys_clock   : system clock, rising edge
//   reset_n     : synchronous active-low reset
//   tx_data     : byte to send, captured when tx_valid & tx_ready
//   tx_valid    : send request
//   tx_ready    : idle, accepts tx_valid this cycle
//   tx_done     : 1-cycle pulse, byte sent and ACKed
//   tx_error    : 1-cycle pulse, timeout or missing ACK
//   busy        : high from accept until the done/error pulse
//   ps2_clk     : PS/2 clock line level (async)
//   ps2_din     : PS/2 data line level (async)
//   ps2_clk_oe  : 1 = pull PS/2 clock low
//   ps2_dat_oe  : 1 = pull PS/2 data low
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1500,
  parameter int RTS_CYCLES     = 30,
  parameter int TIMEOUT_CYCLES = 30000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       sys_clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk,
  input  logic       ps2_din,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // One counter serves the inhibit, RTS and timeout phases, so it is sized for
  // the largest of them.
  localparam int CNT_W = $clog2(INHIBIT_CYCLES + RTS_CYCLES + TIMEOUT_CYCLES + 2);
  localparam int FLT_W = $clog2(FILTER_CYCLES + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_RELEASE, S_DONE, S_ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bcnt;
  logic [9:0]       shreg;

  logic             clk_s1, clk_s2, dat_s1, dat_s2;
  logic             clk_f, fall;
  logic [FLT_W-1:0] fcnt;

  // Synchronisers and clock-level filter. Each synchronised sample that
  // differs from clk_f advances fcnt. clk_f flips only on the FILTER_CYCLES-th
  // consecutive differing sample; a single agreeing sample resets fcnt.
  // Lines idle high, so the reset values are 1.
  always_ff @(posedge sys_clock) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      clk_f  <= 1'b1;
      fcnt   <= '0;
      fall   <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_din;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      if (clk_s2 == clk_f) begin
        fcnt <= '0;
      end else if (fcnt == FLT_LAST) begin
        clk_f <= clk_s2;
        fcnt  <= '0;
        fall  <= ~clk_s2;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Handshake FSM. All outputs are registered. The tx_done and tx_error
  // outputs are high only while the FSM sits in the DONE or ERR state.
  always_ff @(posedge sys_clock) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      busy       <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      cnt        <= '0;
      bcnt       <= '0;
      shreg      <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            shreg    <= {1'b1, ~^tx_data, tx_data};
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            cnt      <= '0;
            state    <= S_INHIBIT;
          end
        end

        // The clock is pulled low on the first INHIBIT edge. The start bit is
        // asserted INHIBIT_CYCLES later.
        S_INHIBIT: begin
          ps2_clk_oe <= 1'b1;
          if (cnt == INH_LAST) begin
            cnt        <= '0;
            ps2_dat_oe <= 1'b1;
            state      <= S_RTS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RTS: begin
          if (cnt == RTS_LAST) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            bcnt       <= '0;
            state      <= S_SEND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // The timeout counter runs from clock release onwards and restarts on
        // every device clock fall.
        S_SEND, S_ACK, S_RELEASE: begin
          cnt <= fall ? '0 : cnt + 1'b1;
          if (!fall && cnt == TO_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            busy       <= 1'b0;
            state      <= S_ERR;
          end else if (state == S_SEND) begin
            // Falls 1..9 carry the data bits and parity. Fall 10 carries the
            // stop bit, whose value of 1 leaves the data line released.
            if (fall) begin
              ps2_dat_oe <= ~shreg[0];
              shreg      <= {1'b0, shreg[9:1]};
              bcnt       <= bcnt + 1'b1;
              if (bcnt == 4'd9) state <= S_ACK;
            end
          end else if (state == S_ACK) begin
            // Fall 11: the device must be holding data low as its ACK.
            if (fall) begin
              if (dat_s2) begin
                tx_error <= 1'b1;
                busy     <= 1'b0;
                state    <= S_ERR;
              end else begin
                state <= S_RELEASE;
              end
            end
          end else if (clk_f && dat_s2) begin
            tx_done <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end
        end

        // A tx_valid arriving during the pulse cycle is not taken. tx_ready
        // returns one cycle later.
        S_DONE, S_ERR: begin
          tx_ready <= 1'b1;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
